// File: rtl/pq_mac_sched_if.sv
// Bundle of the start/operand/result handshake and the shared multiplier/adder ports
// of pq_mac_sched. master = environment side, slave = the scheduler itself.
interface pq_mac_sched_if;
  logic        sta;
  logic [31:0] Vd;
  logic [31:0] Vq;
  logic [31:0] Id;
  logic [31:0] Iq;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_res;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_sub;
  logic [31:0] add_res;
  logic [31:0] P;
  logic [31:0] Q;
  logic        busy;
  logic        done_sig;

  modport master (
    output sta, Vd, Vq, Id, Iq, mul_res, add_res,
    input  mul_a, mul_b, add_a, add_b, add_sub, P, Q, busy, done_sig
  );

  modport slave (
    input  sta, Vd, Vq, Id, Iq, mul_res, add_res,
    output mul_a, mul_b, add_a, add_b, add_sub, P, Q, busy, done_sig
  );
endinterface

// File: rtl/pq_mac_sched.sv
// Time-multiplexed P/Q power calculation on one shared FP multiplier and one shared FP adder.
// Define PQ_SCHED_SCALE_EN to include the final 1.5x scaling pass (SCALE state).
module pq_mac_sched #(
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 7
) (
  input logic           clk,
  input logic           rst,
  pq_mac_sched_if.slave bus
);

  localparam int DATA_W = 32;

`ifdef PQ_SCHED_SCALE_EN
  localparam int LAST_I = 8 + 2*MUL_LAT + ADD_LAT;
`else
  localparam int LAST_I = 6 + MUL_LAT + ADD_LAT;
`endif
  localparam int CNT_W = $clog2(LAST_I + 2);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter value of the cycle in which each event's decision is taken;
  // issues are registered, so they appear on the ports one cycle later.
  localparam cnt_t C_P1      = cnt_t'(1 + MUL_LAT);
  localparam cnt_t C_P2      = cnt_t'(2 + MUL_LAT);
  localparam cnt_t C_P3      = cnt_t'(3 + MUL_LAT);
  localparam cnt_t C_P4      = cnt_t'(4 + MUL_LAT);
  localparam cnt_t C_ADD_ISS = cnt_t'(4 + MUL_LAT);
  localparam cnt_t C_SUB_ISS = cnt_t'(5 + MUL_LAT);
  localparam cnt_t C_SUM     = cnt_t'(5 + MUL_LAT + ADD_LAT);
  localparam cnt_t C_DIF     = cnt_t'(6 + MUL_LAT + ADD_LAT);
`ifdef PQ_SCHED_SCALE_EN
  localparam cnt_t C_SCL_ISS = cnt_t'(7 + MUL_LAT + ADD_LAT);
  localparam cnt_t C_PCAP    = cnt_t'(7 + 2*MUL_LAT + ADD_LAT);
  localparam cnt_t C_QCAP    = cnt_t'(8 + 2*MUL_LAT + ADD_LAT);
  localparam logic [DATA_W-1:0] ONE_P5 = 32'h3FC0_0000;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_SCALE, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_t;
`endif

  state_t            r_state;
  cnt_t              r_cnt;
  logic [DATA_W-1:0] r_vd;
  logic [DATA_W-1:0] r_vq;
  logic [DATA_W-1:0] r_id;
  logic [DATA_W-1:0] r_iq;
  logic [DATA_W-1:0] r_prod1;
  logic [DATA_W-1:0] r_prod2;
  logic [DATA_W-1:0] r_prod3;
  logic [DATA_W-1:0] r_prod4;
`ifdef PQ_SCHED_SCALE_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_diff;
`endif
  logic [DATA_W-1:0] r_p;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic [DATA_W-1:0] r_add_a;
  logic [DATA_W-1:0] r_add_b;
  logic              r_add_sub;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_vd      <= '0;
      r_vq      <= '0;
      r_id      <= '0;
      r_iq      <= '0;
      r_prod1   <= '0;
      r_prod2   <= '0;
      r_prod3   <= '0;
      r_prod4   <= '0;
`ifdef PQ_SCHED_SCALE_EN
      r_sum     <= '0;
      r_diff    <= '0;
`endif
      r_p       <= '0;
      r_q       <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_sub <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Shared-unit ports idle at zero / add mode unless a state issues this cycle.
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_sub <= 1'b1;
      r_done    <= 1'b0;
      if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + cnt_t'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (bus.sta) begin
            r_vd    <= bus.Vd;
            r_vq    <= bus.Vq;
            r_id    <= bus.Id;
            r_iq    <= bus.Iq;
            r_mul_a <= bus.Vd;
            r_mul_b <= bus.Id;
            r_cnt   <= cnt_t'(1);
            r_busy  <= 1'b1;
            r_state <= S_MUL;
          end
        end

        S_MUL: begin
          if (r_cnt == cnt_t'(1)) begin
            r_mul_a <= r_vq;
            r_mul_b <= r_iq;
          end
          if (r_cnt == cnt_t'(2)) begin
            r_mul_a <= r_vq;
            r_mul_b <= r_id;
          end
          if (r_cnt == cnt_t'(3)) begin
            r_mul_a <= r_vd;
            r_mul_b <= r_iq;
          end
          if (r_cnt == C_P1) r_prod1 <= bus.mul_res;
          if (r_cnt == C_P2) r_prod2 <= bus.mul_res;
          if (r_cnt == C_P3) r_prod3 <= bus.mul_res;
          if (r_cnt == C_P4) r_prod4 <= bus.mul_res;
          if (r_cnt == C_ADD_ISS) begin
            r_add_a <= r_prod1;
            r_add_b <= r_prod2;
            r_state <= S_ADD;
          end
        end

        S_ADD: begin
          if (r_cnt == C_SUB_ISS) begin
            r_add_a   <= r_prod3;
            r_add_b   <= r_prod4;
            r_add_sub <= 1'b0;
          end
`ifdef PQ_SCHED_SCALE_EN
          if (r_cnt == C_SUM) r_sum <= bus.add_res;
          if (r_cnt == C_DIF) begin
            r_diff  <= bus.add_res;
            r_mul_a <= r_sum;
            r_mul_b <= ONE_P5;
            r_state <= S_SCALE;
          end
`else
          if (r_cnt == C_SUM) r_p <= bus.add_res;
          if (r_cnt == C_DIF) begin
            r_q     <= bus.add_res;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
`endif
        end

`ifdef PQ_SCHED_SCALE_EN
        S_SCALE: begin
          if (r_cnt == C_SCL_ISS) begin
            r_mul_a <= r_diff;
            r_mul_b <= ONE_P5;
          end
          if (r_cnt == C_PCAP) r_p <= bus.mul_res;
          if (r_cnt == C_QCAP) begin
            r_q     <= bus.mul_res;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif

        // busy drops here so the very next sta is accepted.
        S_DONE: begin
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mul_a    = r_mul_a;
  assign bus.mul_b    = r_mul_b;
  assign bus.add_a    = r_add_a;
  assign bus.add_b    = r_add_b;
  assign bus.add_sub  = r_add_sub;
  assign bus.P        = r_p;
  assign bus.Q        = r_q;
  assign bus.busy     = r_busy;
  assign bus.done_sig = r_done;

endmodule

// File: tb/tb_pq_mac_sched.sv
// Bench for pq_mac_sched: behavioural pipelined FP multiplier/adder plus a P/Q reference
// computed from the power formulas; follows PQ_SCHED_SCALE_EN like the design.
module tb_pq_mac_sched;
  localparam int ML = 5;
  localparam int AL = 7;
  localparam logic [31:0] ONE_P5 = 32'h3FC0_0000;
`ifdef PQ_SCHED_SCALE_EN
  localparam bit SCALE = 1'b1;
  localparam int DONE_CYC = 9 + 2*ML + AL;
  localparam int P_CYC = 8 + 2*ML + AL;
  localparam logic [31:0] SPEC_P = 32'h411C_0000;
  localparam logic [31:0] SPEC_Q = 32'h4040_0000;
`else
  localparam bit SCALE = 1'b0;
  localparam int DONE_CYC = 7 + ML + AL;
  localparam int P_CYC = 6 + ML + AL;
  localparam logic [31:0] SPEC_P = 32'h40D0_0000;
  localparam logic [31:0] SPEC_Q = 32'h4000_0000;
`endif
  localparam int NTR = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_p = '0;
  logic [31:0] exp_q = '0;

  logic [31:0] tr_mula [NTR];
  logic [31:0] tr_mulb [NTR];
  logic [31:0] tr_adda [NTR];
  logic [31:0] tr_addb [NTR];
  logic [31:0] tr_p    [NTR];
  logic [31:0] tr_q    [NTR];
  logic        tr_as   [NTR];
  logic        tr_busy [NTR];
  logic        tr_done [NTR];

  always #5 clk = ~clk;

  pq_mac_sched_if bus();

  pq_mac_sched #(.MUL_LAT(ML), .ADD_LAT(AL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [63:0] sp2dp(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:23] == 8'd0) return {s[31], 63'd0};
    e = 11'(s[30:23]) + 11'd896;
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    logic [10:0] e;
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    return dp2sp($realtobits($bitstoreal(sp2dp(a)) * $bitstoreal(sp2dp(b))));
  endfunction

  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b, input logic add);
    real ra, rb;
    ra = $bitstoreal(sp2dp(a));
    rb = $bitstoreal(sp2dp(b));
    return dp2sp($realtobits(add ? ra + rb : ra - rb));
  endfunction

  // Multiples of 0.5 in [-8, 8] keep every intermediate exact in single precision.
  function automatic logic [31:0] rnd_op();
    int k;
    k = int'($urandom_range(32, 0)) - 16;
    return dp2sp($realtobits(real'(k) * 0.5));
  endfunction

  function automatic logic [31:0] ref_p(input logic [31:0] vd, vq, id, iq);
    logic [31:0] s;
    s = f_add(f_mul(vd, id), f_mul(vq, iq), 1'b1);
    return SCALE ? f_mul(s, ONE_P5) : s;
  endfunction

  function automatic logic [31:0] ref_q(input logic [31:0] vd, vq, id, iq);
    logic [31:0] d;
    d = f_add(f_mul(vq, id), f_mul(vd, iq), 1'b0);
    return SCALE ? f_mul(d, ONE_P5) : d;
  endfunction

  // Shared units: result in cycle k+LAT is the operation on the operands seen in cycle k.
  logic [31:0] mpipe [ML];
  logic [31:0] apipe [AL];
  always @(posedge clk) begin
    mpipe[0] <= f_mul(bus.mul_a, bus.mul_b);
    for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
    apipe[0] <= f_add(bus.add_a, bus.add_b, bus.add_sub);
    for (int i = 1; i < AL; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.mul_res = mpipe[ML-1];
  assign bus.add_res = apipe[AL-1];

  task automatic sample(input int c);
    tr_mula[c] = bus.mul_a;
    tr_mulb[c] = bus.mul_b;
    tr_adda[c] = bus.add_a;
    tr_addb[c] = bus.add_b;
    tr_as[c]   = bus.add_sub;
    tr_busy[c] = bus.busy;
    tr_done[c] = bus.done_sig;
    tr_p[c]    = bus.P;
    tr_q[c]    = bus.Q;
  endtask

  // Cycle 0 is the cycle sta is presented in; cycle c is sampled mid-cycle after c edges.
  task automatic run_trace(input logic [31:0] vd, vq, id, iq, input int sta_cyc,
                           input bit scramble, input int ncyc);
    @(negedge clk);
    bus.Vd = vd; bus.Vq = vq; bus.Id = id; bus.Iq = iq;
    bus.sta = 1'b1;
    sample(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus.sta = (c < sta_cyc);
      if (scramble && c <= 20) begin
        bus.Vd = rnd_op(); bus.Vq = rnd_op(); bus.Id = rnd_op(); bus.Iq = rnd_op();
      end
      sample(c);
    end
    bus.sta = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got [7];
    string nm [7];
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    got = '{bus.P, bus.Q, bus.mul_a, bus.mul_b, bus.add_a, bus.add_b, {31'd0, bus.add_sub}};
    nm  = '{"P", "Q", "mul_a", "mul_b", "add_a", "add_b", "add_sub"};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== ((i == 6) ? 32'd1 : 32'd0)) begin
        errors++;
        $display("FAIL reset_%s got %h want %h", nm[i], got[i], (i == 6) ? 32'd1 : 32'd0);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done_sig !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done got %b%b want 00", bus.busy, bus.done_sig);
    end
    rst = 1'b1;
  endtask

  task automatic test_spec_vector();
    int ndone = 0;
    int first = -1;
    run_trace(32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h3F00_0000, 1, 1'b0, DONE_CYC + 4);
    for (int c = 0; c <= DONE_CYC + 4; c++) begin
      if (tr_done[c]) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL spec_done_count got %0d want 1", ndone); end
    checks++;
    if (first != DONE_CYC) begin errors++; $display("FAIL spec_done_cycle got %0d want %0d", first, DONE_CYC); end
    checks++;
    if (tr_p[DONE_CYC] !== SPEC_P) begin errors++; $display("FAIL spec_P got %h want %h", tr_p[DONE_CYC], SPEC_P); end
    checks++;
    if (tr_q[DONE_CYC] !== SPEC_Q) begin errors++; $display("FAIL spec_Q got %h want %h", tr_q[DONE_CYC], SPEC_Q); end
    checks++;
    if ({tr_busy[0], tr_busy[1], tr_busy[DONE_CYC], tr_busy[DONE_CYC+1]} !== 4'b0110) begin
      errors++;
      $display("FAIL spec_busy_edges got %b want 0110",
               {tr_busy[0], tr_busy[1], tr_busy[DONE_CYC], tr_busy[DONE_CYC+1]});
    end
    exp_p = SPEC_P;
    exp_q = SPEC_Q;
  endtask

  task automatic test_schedule();
    logic [31:0] vd, vq, id, iq, m1, m2, m3, m4, s, d, rp, rq;
    logic [31:0] got [9];
    logic [31:0] want [9];
    string nm [9];
    nm = '{"mul_a", "mul_b", "add_a", "add_b", "add_sub", "busy", "done", "P", "Q"};
    for (int r = 0; r < 2; r++) begin
      vd = rnd_op(); vq = rnd_op(); id = rnd_op(); iq = rnd_op();
      m1 = f_mul(vd, id); m2 = f_mul(vq, iq); m3 = f_mul(vq, id); m4 = f_mul(vd, iq);
      s = f_add(m1, m2, 1'b1); d = f_add(m3, m4, 1'b0);
      rp = ref_p(vd, vq, id, iq); rq = ref_q(vd, vq, id, iq);
      run_trace(vd, vq, id, iq, 1, 1'b0, DONE_CYC + 3);
      for (int c = 0; c <= DONE_CYC + 3; c++) begin
        want = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, exp_p, exp_q};
        if (c == 1) begin want[0] = vd; want[1] = id; end
        if (c == 2) begin want[0] = vq; want[1] = iq; end
        if (c == 3) begin want[0] = vq; want[1] = id; end
        if (c == 4) begin want[0] = vd; want[1] = iq; end
        if (c == 5 + ML) begin want[2] = m1; want[3] = m2; end
        if (c == 6 + ML) begin want[2] = m3; want[3] = m4; want[4] = 32'd0; end
        if (SCALE && c == 7 + ML + AL) begin want[0] = s; want[1] = ONE_P5; end
        if (SCALE && c == 8 + ML + AL) begin want[0] = d; want[1] = ONE_P5; end
        if (c >= 1 && c <= DONE_CYC) want[5] = 32'd1;
        if (c == DONE_CYC) want[6] = 32'd1;
        if (c >= P_CYC) want[7] = rp;
        if (c >= DONE_CYC) want[8] = rq;
        got = '{tr_mula[c], tr_mulb[c], tr_adda[c], tr_addb[c], {31'd0, tr_as[c]},
                {31'd0, tr_busy[c]}, {31'd0, tr_done[c]}, tr_p[c], tr_q[c]};
        for (int i = 0; i < 9; i++) begin
          checks++;
          if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL sched_%s cycle %0d got %h want %h", nm[i], c, got[i], want[i]);
          end
        end
      end
      exp_p = rp;
      exp_q = rq;
    end
  endtask

  task automatic test_scramble();
    logic [31:0] vd, vq, id, iq, rp, rq;
    for (int r = 0; r < 3; r++) begin
      vd = rnd_op(); vq = rnd_op(); id = rnd_op(); iq = rnd_op();
      rp = ref_p(vd, vq, id, iq); rq = ref_q(vd, vq, id, iq);
      run_trace(vd, vq, id, iq, 1, 1'b1, DONE_CYC + 2);
      checks++;
      if (tr_done[DONE_CYC] !== 1'b1) begin errors++; $display("FAIL scram_done got %b want 1", tr_done[DONE_CYC]); end
      checks++;
      if (tr_p[DONE_CYC] !== rp) begin errors++; $display("FAIL scram_P got %h want %h", tr_p[DONE_CYC], rp); end
      checks++;
      if (tr_q[DONE_CYC] !== rq) begin errors++; $display("FAIL scram_Q got %h want %h", tr_q[DONE_CYC], rq); end
      exp_p = rp;
      exp_q = rq;
      bus.Vd = rnd_op(); bus.Vq = rnd_op(); bus.Id = rnd_op(); bus.Iq = rnd_op();
      repeat (6) @(negedge clk);
      checks++;
      if (bus.P !== exp_p || bus.Q !== exp_q) begin
        errors++;
        $display("FAIL hold_PQ got %h/%h want %h/%h", bus.P, bus.Q, exp_p, exp_q);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vd, vq, id, iq;
    int exp_done [$];
    int got_done [$];
    int ncyc;
    vd = rnd_op(); vq = rnd_op(); id = rnd_op(); iq = rnd_op();
    for (int a = 0; a < 40; a += DONE_CYC + 1) exp_done.push_back(a + DONE_CYC);
    ncyc = exp_done[exp_done.size() - 1] + 5;
    run_trace(vd, vq, id, iq, 40, 1'b0, ncyc);
    for (int c = 0; c <= ncyc; c++) if (tr_done[c]) got_done.push_back(c);
    checks++;
    if (got_done.size() != exp_done.size()) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want %0d", got_done.size(), exp_done.size());
    end
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
      checks++;
      if (got_done[i] != exp_done[i]) begin
        errors++;
        $display("FAIL b2b_done_cycle[%0d] got %0d want %0d", i, got_done[i], exp_done[i]);
      end
    end
    checks++;
    if ({tr_busy[DONE_CYC], tr_busy[DONE_CYC+1], tr_busy[DONE_CYC+2]} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_busy_gap got %b want 101",
               {tr_busy[DONE_CYC], tr_busy[DONE_CYC+1], tr_busy[DONE_CYC+2]});
    end
    exp_p = ref_p(vd, vq, id, iq);
    exp_q = ref_q(vd, vq, id, iq);
    checks++;
    if (tr_p[ncyc] !== exp_p || tr_q[ncyc] !== exp_q) begin
      errors++;
      $display("FAIL b2b_PQ got %h/%h want %h/%h", tr_p[ncyc], tr_q[ncyc], exp_p, exp_q);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] vd, vq, id, iq, rp, rq;
    int ndone = 0;
    logic [31:0] got [7];
    @(negedge clk);
    bus.Vd = rnd_op(); bus.Vq = rnd_op(); bus.Id = rnd_op(); bus.Iq = rnd_op();
    bus.sta = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.sta = 1'b0;
    end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", bus.busy); end
    rst = 1'b0;
    #1;
    got = '{bus.P, bus.Q, bus.mul_a, bus.mul_b, bus.add_a, bus.add_b, {31'd0, bus.add_sub}};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== ((i == 6) ? 32'd1 : 32'd0)) begin
        errors++;
        $display("FAIL midrun_rst_out[%0d] got %h want %h", i, got[i], (i == 6) ? 32'd1 : 32'd0);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done_sig !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rst_busy_done got %b%b want 00", bus.busy, bus.done_sig);
    end
    exp_p = '0;
    exp_q = '0;
    repeat (3) begin @(negedge clk); if (bus.done_sig) ndone++; end
    rst = 1'b1;
    repeat (DONE_CYC + 5) begin @(negedge clk); if (bus.done_sig) ndone++; end
    checks++;
    if (ndone != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_abort got done=%0d busy=%b want done=0 busy=0", ndone, bus.busy);
    end
    vd = rnd_op(); vq = rnd_op(); id = rnd_op(); iq = rnd_op();
    rp = ref_p(vd, vq, id, iq); rq = ref_q(vd, vq, id, iq);
    run_trace(vd, vq, id, iq, 1, 1'b0, DONE_CYC + 2);
    checks++;
    if (tr_done[DONE_CYC] !== 1'b1) begin errors++; $display("FAIL rerun_done got %b want 1", tr_done[DONE_CYC]); end
    checks++;
    if (tr_p[P_CYC-1] !== 32'd0) begin errors++; $display("FAIL rerun_P_before got %h want 0", tr_p[P_CYC-1]); end
    checks++;
    if (tr_p[DONE_CYC] !== rp || tr_q[DONE_CYC] !== rq) begin
      errors++;
      $display("FAIL rerun_PQ got %h/%h want %h/%h", tr_p[DONE_CYC], tr_q[DONE_CYC], rp, rq);
    end
    exp_p = rp;
    exp_q = rq;
  endtask

  initial begin
    bus.sta = 1'b0;
    bus.Vd = '0; bus.Vq = '0; bus.Id = '0; bus.Iq = '0;
    test_reset();
    test_spec_vector();
    test_schedule();
    test_scramble();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pq_mac_sched.md
PQ_MAC_SCHED -- requirements
Module: pq_mac_sched

Interface
REQ-001 Parameter MUL_LAT, default 5: pipeline latency in clk cycles of the external shared single-precision multiplier.
REQ-002 Parameter ADD_LAT, default 7: pipeline latency in clk cycles of the external shared single-precision adder/subtractor.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 sta  input  1  start request; sampled on the rising edge.
REQ-006 Vd, Vq, Id, Iq  input  32 each  IEEE-754 single operands.
REQ-007 mul_a, mul_b  output  32 each  operands driven to the shared multiplier.
REQ-008 mul_res  input  32  shared multiplier result.
REQ-009 add_a, add_b  output  32 each  operands driven to the shared adder.
REQ-010 add_sub  output  1  adder mode; 1 = add, 0 = subtract.
REQ-011 add_res  input  32  shared adder result.
REQ-012 P, Q  output  32 each  registered active and reactive power.
REQ-013 busy  output  1  high from the cycle after sta is accepted through the done_sig cycle.
REQ-014 done_sig  output  1  one-cycle pulse when P and Q are updated.

Function
REQ-015 The block SHALL compute P = 1.5*(Vd*Id + Vq*Iq) and Q = 1.5*(Vq*Id - Vd*Iq) using one shared multiplier and one shared adder, both fully pipelined and free-running.
REQ-016 FSM states SHALL be IDLE, MUL, ADD, SCALE, DONE, with a cycle counter that times issue and capture points in every state.
REQ-017 In IDLE, sta=1 SHALL latch Vd/Vq/Id/Iq into internal registers (cycle 0) and enter MUL; sta while busy=1 SHALL be ignored.
REQ-018 The block SHALL issue products Vd*Id, Vq*Iq, Vq*Id, Vd*Iq on mul_a/mul_b in cycles 1, 2, 3, 4, and SHALL capture mul_res for the issue in cycle k in cycle k+MUL_LAT.
REQ-019 The block SHALL issue the add (Vd*Id + Vq*Iq) in cycle 5+MUL_LAT and the subtract (Vq*Id - Vd*Iq) in cycle 6+MUL_LAT, and SHALL capture add_res ADD_LAT cycles after each issue.
REQ-020 The block SHALL issue the sum*0x3FC00000 (1.5) in cycle 7+MUL_LAT+ADD_LAT and the difference*1.5 in cycle 8+MUL_LAT+ADD_LAT, capturing the results into P and Q respectively.
REQ-021 done_sig SHALL be high for exactly one cycle, cycle 9+2*MUL_LAT+ADD_LAT (26 at defaults); the FSM SHALL then return to IDLE, and sta SHALL be accepted again in the next cycle.
REQ-022 P and Q SHALL hold their values between runs and SHALL change only at their capture cycles.
REQ-023 mul_a, mul_b, add_a and add_b SHALL be 0 in every cycle without an issue; add_sub SHALL be 1 except in the subtract issue cycle.
REQ-024 The block SHALL perform no floating-point arithmetic itself; all arithmetic SHALL go through the shared units.

Reset
REQ-025 rst low SHALL immediately force the FSM to IDLE, the counter to 0, P/Q/mul_a/mul_b/add_a/add_b/internal registers to 0, add_sub to 1, and busy/done_sig to 0.
REQ-026 Reset during a run SHALL abort it with no done_sig; the first sta after rst releases SHALL start a full new run.

Configuration
REQ-027 With macro PQ_SCHED_SCALE_EN defined, the SCALE state and the 1.5 multiplies SHALL be present, as in REQ-020/021.
REQ-028 Without PQ_SCHED_SCALE_EN, SCALE SHALL be removed, P and Q SHALL be captured directly from add_res, and done_sig SHALL occur in cycle 7+MUL_LAT+ADD_LAT (19 at defaults).

Verification
REQ-029 Bench models: multiplier with MUL_LAT=5 and adder with ADD_LAT=7, both behavioural. Stimulus Vd=0x40000000, Id=0x40400000, Vq=0x3F800000, Iq=0x3F000000, then sta pulse -> done_sig in cycle 26, P=0x411C0000 (9.75), Q=0x40400000 (3.0).
REQ-030 Same stimulus without PQ_SCHED_SCALE_EN -> done_sig in cycle 19, P=0x40D00000 (6.5), Q=0x40000000 (2.0).
REQ-031 sta held high for 40 cycles -> exactly one run per accept, done_sig pulses 27 cycles apart, busy low for one cycle between runs.
REQ-032 Operands changed in cycles 1-20 of a run -> P/Q equal results for the operands latched at cycle 0.
REQ-033 rst low in cycle 12 of a run -> all outputs 0 immediately, no done_sig; a new sta after release -> correct P/Q in cycle 26.
REQ-034 Every cycle of a run -> mul/add operand ports 0 outside issue cycles, and add_sub=0 only in the subtract issue cycle (cycle 11).
